// File: rtl/gan_stream_pkg.sv
// Shared definitions for the generator stream datapath: word width,
// per-layer frame lengths and a width helper for sizing counters.
package gan_stream_pkg;

    localparam int GAN_DATA_WIDTH = 16;
    localparam int ENC3_FRAME     = 36;
    localparam int DEC1_FRAME     = 81;

    typedef logic signed [GAN_DATA_WIDTH-1:0] act_t;

    // Bits needed to index 'value' items, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < value) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bridge_sdp_ram.sv
// Simple dual-port storage array: one write port, one registered read
// port, no reset on the contents so it maps onto block RAM.
module bridge_sdp_ram
    import gan_stream_pkg::*;
#(
    parameter int DATA_WIDTH = GAN_DATA_WIDTH,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = clog2_min1(DEPTH)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]            raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port; a same-edge write to raddr returns the old word.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/stream_bridge_fifo.sv
// Inter-layer stream bridge: array buffer plus one output register, full
// valid/ready on both sides, almost-full, sticky overflow, flush and a
// frame-boundary marker on the output.
module stream_bridge_fifo
    import gan_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = GAN_DATA_WIDTH,
    parameter int DEPTH        = 1024,
    parameter int AFULL_THRESH = DEPTH - 16,
    parameter int FRAME_LEN    = ENC3_FRAME
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    output logic                         s_ready,
    output logic                         m_valid,
    output logic signed [DATA_WIDTH-1:0] m_data,
    input  logic                         m_ready,
    output logic                         m_last,
    input  logic                         flush,
    input  logic                         clr_err,
    output logic [$clog2(DEPTH+2)-1:0]   level,
    output logic                         almost_full,
    output logic                         overflow
);

    localparam int PTR_W  = clog2_min1(DEPTH);
    localparam int CNT_W  = clog2_min1(DEPTH + 1);
    localparam int LVL_W  = $clog2(DEPTH + 2);
    localparam int BEAT_W = clog2_min1(FRAME_LEN);
    localparam logic [LVL_W-1:0]  AF_LVL    = LVL_W'(AFULL_THRESH);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             rd_addr;
    logic [CNT_W-1:0]             arr_count;
    logic [BEAT_W-1:0]            beat_cnt;
    logic signed [DATA_WIDTH-1:0] rd_data_p0;
    logic                         vld_p0;
    logic                         wr_en;
    logic                         pop;
    logic                         load;

    assign s_ready     = (arr_count < CNT_FULL) && !flush;
    assign wr_en       = s_valid && s_ready;
    assign pop         = m_valid && m_ready;
    // vld_p0 says rd_data_p0 already holds the current array head.
    assign load        = vld_p0 && (arr_count != '0) && (!m_valid || m_ready);
    // Look one entry ahead on a load so the next head is ready next cycle.
    assign rd_addr     = load ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign level       = LVL_W'(arr_count) + LVL_W'(m_valid);
    assign almost_full = level >= AF_LVL;
    assign m_last      = m_valid && (beat_cnt == BEAT_LAST);

    // ---- p0: registered array read of the head entry ----
    bridge_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (s_data),
        .raddr (rd_addr),
        .rdata (rd_data_p0)
    );

    // Pointers, array occupancy, head validity, output valid and frame beat.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            arr_count <= '0;
            vld_p0    <= 1'b0;
            m_valid   <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load)  rd_ptr <= rd_ptr + PTR_W'(1);
            arr_count <= arr_count + CNT_W'(wr_en) - CNT_W'(load);
            // Head is readable only if it was stored before this edge.
            vld_p0    <= (arr_count - CNT_W'(load)) != '0;
            if (load)     m_valid <= 1'b1;
            else if (pop) m_valid <= 1'b0;
            if (pop) beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

    // ---- p1: output register, holds while the consumer stalls ----
    always_ff @(posedge clk) begin
        if (!rst_n)              m_data <= '0;
        else if (load && !flush) m_data <= rd_data_p0;
    end

    // Sticky drop flag; a new drop beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)                          overflow <= 1'b0;
        else if (s_valid && !s_ready && !flush) overflow <= 1'b1;
        else if (clr_err)                    overflow <= 1'b0;
    end

endmodule

// File: tb/tb_stream_bridge_fifo.sv
// Bench for stream_bridge_fifo with a small array and short frames.
module tb_stream_bridge_fifo;

    localparam int DW = 16;
    localparam int DP = 8;
    localparam int AF = 6;
    localparam int FL = 4;
    localparam int LW = $clog2(DP + 2);

    logic                 clk;
    logic                 rst_n;
    logic                 s_valid;
    logic signed [DW-1:0] s_data;
    logic                 s_ready;
    logic                 m_valid;
    logic signed [DW-1:0] m_data;
    logic                 m_ready;
    logic                 m_last;
    logic                 flush;
    logic                 clr_err;
    logic [LW-1:0]        level;
    logic                 almost_full;
    logic                 overflow;

    stream_bridge_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DP),
        .AFULL_THRESH (AF),
        .FRAME_LEN    (FL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .flush       (flush),
        .clr_err     (clr_err),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // Reference: words held in order, beat position in frame, seen frame ends.
    logic signed [DW-1:0] model_q[$];
    logic signed [DW-1:0] last_q[$];
    int  exp_beat = 0;
    int  rx_cnt   = 0;
    bit  mon_en   = 1'b0;
    bit  acc      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check the held state against the model at the negedge,
    // record the handshakes that the coming edge performs, then step past it.
    task automatic tick();
        @(negedge clk);
        acc = 1'b0;
        if (mon_en) begin
            check("level", 32'(level), model_q.size());
            check("almost_full", 32'(almost_full), 32'(model_q.size() >= AF));
            if (m_valid) begin
                check("head_present", 32'(model_q.size() != 0), 1);
                if (model_q.size() != 0) begin
                    check("head_data", m_data, model_q[0]);
                    check("head_last", 32'(m_last), 32'(exp_beat == FL - 1));
                end
            end else begin
                check("idle_last", 32'(m_last), 0);
            end
        end
        if (!rst_n || flush) begin
            model_q.delete();
            exp_beat = 0;
        end else begin
            if (m_valid && m_ready && model_q.size() != 0) begin
                if (m_last) last_q.push_back(m_data);
                void'(model_q.pop_front());
                exp_beat = (exp_beat + 1) % FL;
                rx_cnt++;
            end
            if (s_valid && s_ready) begin
                model_q.push_back(s_data);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && model_q.size() != 0; c++) tick();
        check("drain_empty", model_q.size(), 0);
    endtask

    task automatic send(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(base + i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    // Flush (or reset) after two pops of a six-word burst, then a fresh frame.
    task automatic discard_case(input bit use_rst, input int base);
        rst_pulse();
        send(base, 6);
        m_ready = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h7777;
        if (use_rst) rst_n = 1'b0;
        else         flush = 1'b1;
        tick();
        rst_n   = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        check("disc_level", 32'(level), 0);
        check("disc_mvalid", 32'(m_valid), 0);
        check("disc_ovf", 32'(overflow), 0);
        tick();
        tick();
        check("disc_quiet", 32'(m_valid), 0);
        last_q.delete();
        m_ready = 1'b1;
        send(base + 10, 4);
        drain(20);
        check("disc_last_cnt", last_q.size(), 1);
        if (last_q.size() == 1) check("disc_last_val", last_q[0], 32'(base + 13));
    endtask

    int sent;

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h5a5a;
        m_ready = 1'b0;

        // Reset held three cycles with a valid word offered.
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        check("rst_mvalid", 32'(m_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_mdata", m_data, 0);
        check("rst_mlast", 32'(m_last), 0);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        tick();
        check("rst_sready", 32'(s_ready), 1);

        // Single beat latency.
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        tick();
        s_valid = 1'b0;
        check("lat_k0", 32'(m_valid), 0);
        tick();
        check("lat_k1", 32'(m_valid), 0);
        tick();
        check("lat_k2_valid", 32'(m_valid), 1);
        check("lat_k2_data", m_data, 32'hffff_1234 & 32'h0000_ffff);
        tick();
        check("lat_level", 32'(level), 0);
        check("lat_mvalid", 32'(m_valid), 0);

        // Fill with the consumer stalled.
        rst_pulse();
        send(0, 10);
        check("fill_level", 32'(level), 9);
        check("fill_sready", 32'(s_ready), 0);
        check("fill_ovf", 32'(overflow), 1);
        check("fill_afull", 32'(almost_full), 1);
        s_valid = 1'b1;
        s_data  = 16'h00aa;
        clr_err = 1'b1;
        tick();
        s_valid = 1'b0;
        clr_err = 1'b0;
        check("ovf_set_wins", 32'(overflow), 1);
        rx_cnt  = 0;
        m_ready = 1'b1;
        drain(40);
        check("fill_drain_cnt", rx_cnt, 9);
        m_ready = 1'b0;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        check("flush_keeps_ovf", 32'(overflow), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_ovf", 32'(overflow), 0);

        // Random backpressure on both sides with a ramp.
        rst_pulse();
        sent   = 0;
        rx_cnt = 0;
        for (int c = 0; c < 3000 && rx_cnt < 200; c++) begin
            s_valid = (sent < 200) && ($urandom_range(0, 1) == 1);
            s_data  = 16'(sent);
            m_ready = ($urandom_range(0, 1) == 1);
            tick();
            if (acc) sent++;
        end
        s_valid = 1'b0;
        check("bp_sent", sent, 200);
        check("bp_recv", rx_cnt, 200);

        // Frame markers on 3, 7, 11.
        rst_pulse();
        last_q.delete();
        m_ready = 1'b1;
        send(0, 12);
        drain(20);
        check("frame_last_cnt", last_q.size(), 3);
        for (int k = 0; k < last_q.size(); k++) check("frame_last_val", last_q[k], 32'(4 * k + 3));

        // Marker held while the last beat stalls.
        m_ready = 1'b0;
        send(12, 4);
        tick();
        check("stall_head_valid", 32'(m_valid), 1);
        check("stall_head_data", m_data, 12);
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_last", 32'(m_last), 1);
            check("stall_data", m_data, 15);
            tick();
        end
        m_ready = 1'b1;
        tick();
        check("stall_done_level", 32'(level), 0);

        // Discard mid-frame by flush, then by reset.
        discard_case(1'b0, 20);
        discard_case(1'b1, 40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
